// File: rtl/decode_queue_if.sv
// decode_queue_if: bundles the fetch-side, issue-side and status signals of the
// instruction decode queue.
//   flush        : branch taken; empties the queue and squashes the next fetch pair
//   instr1/2     : older/younger fetched words, 16'h0 marks a bubble
//   stall        : registered back-pressure to fetch
//   issue_instr* : two oldest queued words, zero when the matching valid is low
//   issue_valid* : occupancy >= 1 / >= 2
//   issue_take   : words consumed by issue this cycle (0..2, 3 treated as 2)
//   count        : current occupancy
//   overflow     : sticky flag, set when an incoming word had to be dropped
// The master modport is the fetch/issue environment; the slave modport is the queue.
interface decode_queue_if #(
  parameter int unsigned DEPTH = 8
) ();
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            flush;
  logic [15:0]     instr1;
  logic [15:0]     instr2;
  logic            stall;
  logic [15:0]     issue_instr0;
  logic [15:0]     issue_instr1;
  logic            issue_valid0;
  logic            issue_valid1;
  logic [1:0]      issue_take;
  logic [CntW-1:0] count;
  logic            overflow;

  modport master (
    output flush,
    output instr1,
    output instr2,
    output issue_take,
    input  stall,
    input  issue_instr0,
    input  issue_instr1,
    input  issue_valid0,
    input  issue_valid1,
    input  count,
    input  overflow
  );

  modport slave (
    input  flush,
    input  instr1,
    input  instr2,
    input  issue_take,
    output stall,
    output issue_instr0,
    output issue_instr1,
    output issue_valid0,
    output issue_valid1,
    output count,
    output overflow
  );
endinterface

// File: rtl/decode_queue.sv
// decode_queue: circular instruction FIFO between fetch and decode/issue.
// Accepts a two-wide pair per cycle, drops bubble words (16'h0), presents the two
// oldest entries combinationally and drives registered back-pressure to fetch.
// A flush empties the queue and discards the single stale pair fetch emits next.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high, clears all state
//   bus   : decode_queue_if.slave (see interface header for signal list)
module decode_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  decode_queue_if.slave  bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt    = CntW'(DEPTH);
  // Keeps two entries free for the pair already in flight when fetch sees stall.
  localparam logic [CntW-1:0] StallThresh = CntW'(DEPTH - 4);

  logic [15:0]     mem_q [DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PtrW-1:0] head_p1, tail_p1;
  logic [CntW-1:0] count_q, count_d;
  logic            stall_q, stall_d;
  logic            squash_q, squash_d;
  logic            overflow_q, overflow_d;

  logic [1:0]      take;
  logic [1:0]      n_out;
  logic [1:0]      n_in;
  logic [1:0]      n_acc;
  logic [CntW-1:0] free;
  logic            drop;
  logic [15:0]     word0, word1;
  logic            we0, we1;

  assign head_p1 = head_q + 1'b1;
  assign tail_p1 = tail_q + 1'b1;

  // Compact the incoming pair: word0 is the oldest non-bubble word.
  always_comb begin
    word0 = 16'h0;
    word1 = 16'h0;
    n_in  = 2'd0;
    if (bus.instr1 != 16'h0) begin
      word0 = bus.instr1;
      word1 = bus.instr2;
      n_in  = (bus.instr2 != 16'h0) ? 2'd2 : 2'd1;
    end else if (bus.instr2 != 16'h0) begin
      word0 = bus.instr2;
      n_in  = 2'd1;
    end
    // The pair after a flush is wrong-path.
    if (squash_q) begin
      n_in = 2'd0;
    end
  end

  // Dequeue amount and space accounting.
  always_comb begin
    take = (bus.issue_take == 2'd3) ? 2'd2 : bus.issue_take;
    if (count_q < {{(CntW-2){1'b0}}, take}) begin
      n_out = count_q[1:0];
    end else begin
      n_out = take;
    end
    // Entries leaving this cycle free space for entries arriving this cycle.
    free = DepthCnt - count_q + {{(CntW-2){1'b0}}, n_out};
    drop = {{(CntW-2){1'b0}}, n_in} > free;
    // Only reachable when free < 2, so free[1:0] holds the whole value.
    n_acc = drop ? free[1:0] : n_in;
  end

  // Next-state logic; flush takes priority over enqueue and dequeue.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    stall_d    = stall_q;
    squash_d   = 1'b0;
    overflow_d = overflow_q;
    we0        = 1'b0;
    we1        = 1'b0;
    if (bus.flush) begin
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      stall_d  = 1'b0;
      squash_d = 1'b1;
    end else begin
      head_d     = head_q + PtrW'(n_out);
      tail_d     = tail_q + PtrW'(n_acc);
      count_d    = count_q + CntW'(n_acc) - CntW'(n_out);
      stall_d    = count_d > StallThresh;
      overflow_d = overflow_q | drop;
      we0        = n_acc != 2'd0;
      we1        = n_acc == 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      stall_q    <= 1'b0;
      squash_q   <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 16'h0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      stall_q    <= stall_d;
      squash_q   <= squash_d;
      overflow_q <= overflow_d;
      if (we0) begin
        mem_q[tail_q] <= word0;
      end
      // tail_p1 wraps, so a pair may straddle the last and first entries.
      if (we1) begin
        mem_q[tail_p1] <= word1;
      end
    end
  end

  always_comb begin
    bus.issue_valid0 = count_q != '0;
    bus.issue_valid1 = count_q > CntW'(1);
    bus.issue_instr0 = bus.issue_valid0 ? mem_q[head_q] : 16'h0;
    bus.issue_instr1 = bus.issue_valid1 ? mem_q[head_p1] : 16'h0;
    bus.stall        = stall_q;
    bus.count        = count_q;
    bus.overflow     = overflow_q;
  end
endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_queue_if #(.DEPTH(DEPTH)) bus ();

  decode_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: scoreboard of queued words plus the registered flags.
  logic [15:0] sb[$];
  logic        m_stall;
  logic        m_squash;
  logic        m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    int n;
    n = sb.size();
    check("count", 32'(bus.count), 32'(n));
    check("valid0", 32'(bus.issue_valid0), 32'(n >= 1));
    check("valid1", 32'(bus.issue_valid1), 32'(n >= 2));
    check("instr0", 32'(bus.issue_instr0), (n >= 1) ? 32'(sb[0]) : 32'h0);
    check("instr1", 32'(bus.issue_instr1), (n >= 2) ? 32'(sb[1]) : 32'h0);
    check("stall", 32'(bus.stall), 32'(m_stall));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
  endtask

  task automatic push(input logic [15:0] w);
    if (sb.size() < int'(DEPTH)) sb.push_back(w);
    else m_ovf = 1'b1;
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance the model.
  task automatic step(input logic [15:0] a, input logic [15:0] b, input logic [1:0] take,
                      input logic fl);
    int n_out;
    logic [15:0] exp;
    bus.instr1     = a;
    bus.instr2     = b;
    bus.issue_take = take;
    bus.flush      = fl;
    @(negedge clk);
    check_state();
    if (fl) begin
      sb.delete();
      m_squash = 1'b1;
      m_stall  = 1'b0;
    end else begin
      n_out = (take == 2'd3) ? 2 : int'(take);
      if (n_out > sb.size()) n_out = sb.size();
      for (int i = 0; i < n_out; i++) begin
        exp = sb.pop_front();
        check("issue_pop", 32'((i == 0) ? bus.issue_instr0 : bus.issue_instr1), 32'(exp));
      end
      if (!m_squash) begin
        if (a != 16'h0) push(a);
        if (b != 16'h0) push(b);
      end
      m_squash = 1'b0;
      m_stall  = sb.size() > int'(DEPTH) - 4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.flush      = 1'b0;
    bus.instr1     = 16'h0;
    bus.instr2     = 16'h0;
    bus.issue_take = 2'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    sb.delete();
    m_stall  = 1'b0;
    m_squash = 1'b0;
    m_ovf    = 1'b0;
    check_state();
  endtask

  initial begin
    logic stall_prev;
    logic stall_now;
    logic [15:0] ra, rb;

    do_reset();

    // Streaming and first-word latency.
    step(16'h1111, 16'h2222, 2'd0, 1'b0);
    check("t1_count2", 32'(bus.count), 32'd2);
    check("t1_instr0", 32'(bus.issue_instr0), 32'h1111);
    check("t1_instr1", 32'(bus.issue_instr1), 32'h2222);
    step(16'h3333, 16'h4444, 2'd0, 1'b0);
    check("t1_count4", 32'(bus.count), 32'd4);
    step(16'h0, 16'h0, 2'd2, 1'b0);
    step(16'h0, 16'h0, 2'd1, 1'b0);
    step(16'h0, 16'h0, 2'd3, 1'b0);  // take 3 treated as 2, clamped to count 1
    check("t1_drained", 32'(bus.count), 32'd0);

    // Bubble filtering.
    step(16'h0000, 16'hAAAA, 2'd0, 1'b0);
    step(16'hBBBB, 16'h0000, 2'd0, 1'b0);
    step(16'h0000, 16'h0000, 2'd0, 1'b0);
    check("t2_count", 32'(bus.count), 32'd2);
    check("t2_instr0", 32'(bus.issue_instr0), 32'hAAAA);
    check("t2_instr1", 32'(bus.issue_instr1), 32'hBBBB);
    step(16'h0, 16'h0, 2'd2, 1'b0);

    // Back-pressure with a fetch that reacts to stall one cycle late.
    do_reset();
    stall_prev = 1'b0;
    for (int k = 0; k < 7; k++) begin
      stall_now = bus.stall;
      if (!stall_prev) step(16'h1000 + 16'(2 * k + 1), 16'h1000 + 16'(2 * k + 2), 2'd0, 1'b0);
      else step(16'h0, 16'h0, 2'd0, 1'b0);
      stall_prev = stall_now;
    end
    check("t3_count", 32'(bus.count), 32'd8);
    check("t3_stall", 32'(bus.stall), 32'd1);
    check("t3_ovf", 32'(bus.overflow), 32'd0);

    // Simultaneous enqueue and dequeue on a full queue, across the pointer wrap.
    step(16'h5555, 16'h6666, 2'd2, 1'b0);
    check("t4_count", 32'(bus.count), 32'd8);
    for (int k = 0; k < 4; k++) step(16'h0, 16'h0, 2'd2, 1'b0);
    check("t4_empty", 32'(bus.count), 32'd0);
    check("t4_stall", 32'(bus.stall), 32'd0);

    // Flush and squash of the following pair.
    step(16'hA001, 16'hA002, 2'd0, 1'b0);
    step(16'hA003, 16'hA004, 2'd0, 1'b0);
    step(16'hA005, 16'h0000, 2'd0, 1'b0);
    check("t5_count5", 32'(bus.count), 32'd5);
    step(16'h0, 16'h0, 2'd0, 1'b1);
    check("t5_flushed", 32'(bus.count), 32'd0);
    step(16'h7777, 16'h8888, 2'd0, 1'b0);
    check("t5_squashed", 32'(bus.count), 32'd0);
    step(16'h9999, 16'hAAAA, 2'd0, 1'b0);
    check("t5_resume", 32'(bus.count), 32'd2);
    check("t5_instr0", 32'(bus.issue_instr0), 32'h9999);
    // Back-to-back flush keeps squash armed.
    step(16'h0, 16'h0, 2'd0, 1'b1);
    step(16'hB001, 16'hB002, 2'd0, 1'b1);
    step(16'hB003, 16'hB004, 2'd0, 1'b0);
    check("t5_reflush", 32'(bus.count), 32'd0);

    // Overflow when stall is ignored.
    do_reset();
    step(16'hC001, 16'hC002, 2'd0, 1'b0);
    step(16'hC003, 16'hC004, 2'd0, 1'b0);
    step(16'hC005, 16'hC006, 2'd0, 1'b0);
    step(16'hC007, 16'h0000, 2'd0, 1'b0);
    check("t6_count7", 32'(bus.count), 32'd7);
    step(16'h1234, 16'h5678, 2'd0, 1'b0);
    check("t6_count8", 32'(bus.count), 32'd8);
    check("t6_ovf", 32'(bus.overflow), 32'd1);
    for (int k = 0; k < 4; k++) step(16'h0, 16'h0, 2'd2, 1'b0);
    check("t6_ovf_sticky", 32'(bus.overflow), 32'd1);
    do_reset();
    check("t6_ovf_clear", 32'(bus.overflow), 32'd0);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      ra = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 16'hFFFF));
      rb = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 16'hFFFF));
      if (bus.stall && $urandom_range(0, 7) != 0) begin
        ra = 16'h0;
        rb = 16'h0;
      end
      step(ra, rb, 2'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/decode_queue.md
# decode_queue

Instruction decode queue sitting between `fetch_unit` and the decode/issue stage. Each cycle it accepts the two-wide instruction pair from fetch, drops bubble words (16'h0), and buffers the rest in order in a circular FIFO. It presents up to two oldest instructions to issue per cycle and drives the `stall` back-pressure line to fetch. A branch-taken flush empties the queue and squashes the one wrong-path pair still in flight from fetch.

## Interface
- `DEPTH`, 8: queue entries, 16-bit each; power of two, ≥ 4.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `flush`  in  1  branch taken; tied to the same net as fetch `is_branch_taken`.
- `instr1`  in  16  older fetched instruction; 16'h0 = bubble.
- `instr2`  in  16  younger fetched instruction; 16'h0 = bubble.
- `stall`  out  1  registered back-pressure to fetch `stall`.
- `issue_instr0`  out  16  oldest queued instruction; 16'h0 when `issue_valid0` is low.
- `issue_instr1`  out  16  second-oldest queued instruction; 16'h0 when `issue_valid1` is low.
- `issue_valid0`  out  1  count ≥ 1.
- `issue_valid1`  out  1  count ≥ 2.
- `issue_take`  in  2  number consumed this cycle: 0, 1 or 2.
- `count`  out  log2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky error flag.

## Operation
- State: storage array, `head` and `tail` pointers (log2(DEPTH) bits each, wrap naturally), `count`, registered `stall`, `squash` flag, `overflow` flag.
- Enqueue: `n_in` is the number of non-zero words in {`instr1`, `instr2`}, range 0–2. Words are written at `tail` in order, `instr1` first. Zero words are skipped, not stored.
- Dequeue: `n_out` = `issue_take` clamped to `count` (0, 1 or 2). `head` advances by `n_out`.
- Issue outputs are combinational reads of storage at `head` and `head+1` (mod DEPTH), gated by `issue_valid0` and `issue_valid1`.
- Simultaneous enqueue and dequeue: free space = DEPTH − count + n_out, so dequeue frees space in the same cycle. `count_next` = count + n_in_accepted − n_out.
- Overflow: if n_in exceeds free space, accept only the older words that fit, drop the rest, and set `overflow` = 1. `overflow` clears only on `reset`. This case cannot occur while fetch honours `stall`.
- Stall: at each edge, `stall` <= (count_next > DEPTH−4). This reserves two entries for the one pair already in flight when fetch first samples `stall`.
- Flush (priority over enqueue and dequeue):
  - On the edge, `head`, `tail` and `count` are set to 0, `stall` to 0, and `squash` to 1.
  - While `squash` = 1, the incoming pair is discarded (fetch emits one stale pair after a branch). `squash` clears at that edge.
  - Dequeue still proceeds normally in the squash cycle.
- `flush` during a squash cycle: state resets again and `squash` stays 1.
- `reset` takes priority over `flush`.
- Illegal `issue_take` = 3 is treated as 2, then clamped to `count`.

## Timing
- Reset values: `stall`=0, `count`=0, `issue_valid0/1`=0, `issue_instr0/1`=16'h0, `overflow`=0, `squash`=0, pointers 0.
- Latency: a word presented in cycle N is visible on `issue_instr0` in cycle N+1 if the queue was empty.
- `issue_take` in cycle N removes entries at the edge ending cycle N. The next entries appear in cycle N+1.
- `stall` updates one edge after the enqueue that crosses the threshold; it deasserts the edge after `count_next` ≤ DEPTH−4.
- Flush asserted in cycle N: queue is empty in N+1, the pair in N+1 is dropped, and enqueue resumes in cycle N+2.
- Wrap-around: pointers wrap mod DEPTH. A pair may be split across the last and first entries.

## Test plan
- Reset then stream pairs {0x1111,0x2222}, {0x3333,0x4444} with `issue_take`=0 → `count`=2 then 4. `issue_instr0`=0x1111 and `issue_instr1`=0x2222 in the cycle after the first pair.
- Bubble filtering: pairs {0x0000,0xAAAA}, {0xBBBB,0x0000}, {0,0} → queue holds 0xAAAA then 0xBBBB, `count`=2.
- Back-pressure (DEPTH=8): full-rate pairs with `issue_take`=0 → `stall` rises after `count` reaches 6. The in-flight pair fills the queue to 8, then fetch emits zeros. `overflow` stays 0.
- Simultaneous: `count`=8, `issue_take`=2, pair {0x5555,0x6666} → `count` stays 8, order preserved, 0x5555 follows the old tail across the pointer wrap.
- Flush: `count`=5, assert `flush` for one cycle, next-cycle pair {0x7777,0x8888} → `count`=0 and that pair is dropped. The following pair {0x9999,0xAAAA} is enqueued, `count`=2.
- Overflow: ignore `stall`, drive {0x1234,0x5678} when `count`=7 and `issue_take`=0 → only 0x1234 is stored, `count`=8, `overflow`=1 until `reset`.
